topk_result_serializer: RTL and testbench



---
 rtl/topk_result_serializer.sv | 87 ++++++++
 tb/tb_topk_result_serializer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/topk_result_serializer.sv
// topk_result_serializer: captures a top-K sorter frame and streams its valid entries over valid/ready
module topk_result_serializer #(
  parameter int DATA_LENGTH = 14,
  parameter int OUT_NUM = 4,
  parameter int NUM_WIDTH = 6,
  parameter int RANK_WIDTH = 2,
  parameter int CNT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sort_finish,
  input  logic [DATA_LENGTH-1:0] sorted_data [OUT_NUM],
  input  logic [NUM_WIDTH-1:0]   sorted_addr [OUT_NUM],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic [NUM_WIDTH-1:0]   out_addr,
  output logic [RANK_WIDTH-1:0]  out_rank,
  output logic                   out_last,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   valid_count,
  output logic                   empty_frame,
  output logic                   overrun
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [RANK_WIDTH-1:0] idx, idx_n;
  logic [DATA_LENGTH-1:0] buf_data [OUT_NUM];
  logic [NUM_WIDTH-1:0] buf_addr [OUT_NUM];
  logic [CNT_WIDTH-1:0] count;
  logic run, cap, hs, ovr_n, emp_n;
  assign out_valid = state == STREAM;
  assign busy = out_valid;
  assign hs = out_valid && out_ready;
  assign out_data = out_valid ? buf_data[idx] : '0;
  assign out_addr = out_valid ? buf_addr[idx] : '0;
  assign out_rank = out_valid ? idx : '0;
  assign out_last = out_valid && (CNT_WIDTH'(idx) == valid_count - 1'b1);
  // count the leading run of valid slots; anything after the first sentinel is ignored
  always_comb begin
    count = '0;
    run = 1'b1;
    for (int i = 0; i < OUT_NUM; i++) begin
      run = run & (sorted_data[i] != '1);
      count = count + CNT_WIDTH'(run);
    end
  end
  // a new frame is taken when idle or on the final handshake, otherwise it is dropped
  always_comb begin
    state_n = state;
    idx_n = idx;
    cap = 1'b0;
    ovr_n = 1'b0;
    emp_n = 1'b0;
    if (!out_valid || (hs && out_last)) begin
      cap = sort_finish;
      state_n = (sort_finish && count != '0) ? STREAM : IDLE;
      idx_n = '0;
      emp_n = sort_finish && count == '0;
    end else begin
      idx_n = hs ? idx + 1'b1 : idx;
      ovr_n = sort_finish;
    end
  end
  // state, beat index, status pulses and capture buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      buf_data <= '{default: '1};
      buf_addr <= '{default: '0};
      valid_count <= '0;
      empty_frame <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      empty_frame <= emp_n;
      overrun <= ovr_n;
      if (cap) begin
        buf_data <= sorted_data;
        buf_addr <= sorted_addr;
        valid_count <= count;
      end
    end
  end
endmodule

// File: tb/tb_topk_result_serializer.sv
// tb_topk_result_serializer: directed and randomized checks against a beat-queue reference model
module tb_topk_result_serializer;
  localparam int DL = 14, ON = 4, NW = 6, RW = 2, CW = 3;
  logic clk = 0, rst = 1, sort_finish = 0, out_ready = 0;
  logic [DL-1:0] sorted_data [ON];
  logic [NW-1:0] sorted_addr [ON];
  logic out_valid, out_last, busy, empty_frame, overrun;
  logic [DL-1:0] out_data;
  logic [NW-1:0] out_addr;
  logic [RW-1:0] out_rank;
  logic [CW-1:0] valid_count;
  always #5 clk = ~clk;
  topk_result_serializer #(.DATA_LENGTH(DL), .OUT_NUM(ON), .NUM_WIDTH(NW), .RANK_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .sort_finish(sort_finish), .sorted_data(sorted_data), .sorted_addr(sorted_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_rank(out_rank),
    .out_last(out_last), .busy(busy), .valid_count(valid_count), .empty_frame(empty_frame), .overrun(overrun));
  typedef struct {logic [DL-1:0] d; logic [NW-1:0] a; int r;} beat_t;
  beat_t q[$];
  int exp_vc, n_chk, n_fail;
  bit exp_ovr, exp_emp;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic load(input int d0, d1, d2, d3, a0, a1, a2, a3);
    sorted_data[0] = DL'(d0); sorted_data[1] = DL'(d1); sorted_data[2] = DL'(d2); sorted_data[3] = DL'(d3);
    sorted_addr[0] = NW'(a0); sorted_addr[1] = NW'(a1); sorted_addr[2] = NW'(a2); sorted_addr[3] = NW'(a3);
  endtask
  task automatic rand_frame();
    int n, v;
    n = $urandom_range(0, ON);
    v = $urandom_range(0, 3000);
    for (int k = 0; k < ON; k++) begin
      v += $urandom_range(0, 500);
      sorted_addr[k] = NW'($urandom);
      sorted_data[k] = (k < n) ? DL'(v) : (k == n || $urandom_range(0, 1) == 0) ? '1 : DL'($urandom_range(0, 9000));
    end
  endtask
  task automatic model_step();
    bit hs;
    hs = q.size() > 0 && out_ready;
    if (hs) void'(q.pop_front());
    exp_ovr = 0;
    exp_emp = 0;
    if (sort_finish) begin
      if (q.size() == 0) begin
        for (int k = 0; k < ON && sorted_data[k] != '1; k++) q.push_back('{sorted_data[k], sorted_addr[k], k});
        exp_vc = q.size();
        exp_emp = q.size() == 0;
      end else exp_ovr = 1;
    end
  endtask
  task automatic cycle(input bit sf, input bit rdy, input bit r);
    rst = r;
    sort_finish = sf;
    out_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_vc = 0;
      exp_ovr = 0;
      exp_emp = 0;
    end else model_step();
    @(negedge clk);
    sort_finish = 0;
    rst = 0;
    for (int k = 0; k < ON; k++) begin
      sorted_data[k] = DL'($urandom);
      sorted_addr[k] = NW'($urandom);
    end
    check("out_valid", out_valid, q.size() > 0);
    check("busy", busy, q.size() > 0);
    check("out_last", out_last, q.size() == 1);
    check("valid_count", valid_count, exp_vc);
    check("empty_frame", empty_frame, exp_emp);
    check("overrun", overrun, exp_ovr);
    if (q.size() > 0) begin
      check("out_data", out_data, q[0].d);
      check("out_addr", out_addr, q[0].a);
      check("out_rank", out_rank, q[0].r);
    end
    if (r) begin
      check("rst_data", out_data, 0);
      check("rst_addr", out_addr, 0);
      check("rst_rank", out_rank, 0);
    end
  endtask
  initial begin
    load(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    load(5, 9, 12, 30, 3, 17, 0, 39);
    cycle(1, 1, 0);
    repeat (5) cycle(0, 1, 0);
    load(7, 'h3FFF, 'h3FFF, 'h3FFF, 10, 63, 63, 63);
    cycle(1, 1, 0);
    repeat (3) cycle(0, 1, 0);
    load('h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 1, 2, 3, 4);
    cycle(1, 1, 0);
    repeat (3) cycle(0, 1, 0);
    load(5, 9, 12, 30, 3, 17, 0, 39);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);
    repeat (4) cycle(0, 1, 0);
    load(100, 200, 300, 400, 1, 2, 3, 4);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    load(1, 2, 3, 4, 5, 6, 7, 8);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    load(40, 41, 'h3FFF, 43, 20, 21, 22, 23);
    cycle(1, 1, 0);
    repeat (3) cycle(0, 1, 0);
    load(11, 22, 33, 44, 9, 8, 7, 6);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 1);
    load(50, 60, 70, 80, 1, 1, 2, 2);
    cycle(1, 1, 0);
    repeat (5) cycle(0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      bit sf;
      sf = $urandom_range(0, 5) == 0;
      if (sf) rand_frame();
      cycle(sf, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
